display_scan_manager: RTL and testbench
=======================================

# display_scan_manager

Parametrised successor to the four-digit display manager. It captures a binary value on an update strobe and formats it as hex, decimal, ones-count or zeros-count using a multi-cycle sequential binary-to-BCD converter. It holds the formatted frame and time-multiplexes it onto a DIGITS-wide seven-segment bank, one digit at a time. It sits between the counter/datapath logic and the seven-segment decoder.

## Interface
- `WIDTH`, 16: bit width of input value; must satisfy WIDTH < 10^DIGITS.
- `DIGITS`, 4: number of display digits.
- `SCAN_DIV`, 4: clocks per digit scan slot; ≥ 1.
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `update`  in  1  one-cycle strobe; capture `value`/`mode` when idle.
- `value`  in  WIDTH  binary value to display.
- `mode`  in  2  0 = HEX, 1 = DEC, 2 = ONES, 3 = ZEROS.
- `busy`  out  1  conversion in progress.
- `done`  out  1  one-cycle pulse when a new frame is committed.
- `dig_sel`  out  DIGITS  one-hot active-high digit enable.
- `dig_code`  out  5  code for the selected digit: 0–15 hex glyph, 16 BLANK, 17 DASH.

## Operation
- FSM states: IDLE, CONV, COMMIT.
- IDLE:
  - `update` = 1 → snapshot `value` and `mode`.
  - HEX → COMMIT.
  - Otherwise → CONV with operand loaded into the converter:
    - DEC: operand = value.
    - ONES: operand = popcount(value).
    - ZEROS: operand = WIDTH − popcount(value).
- CONV: double-dabble, one shift per clock for exactly WIDTH clocks, then COMMIT.
- COMMIT: write the whole frame atomically, pulse `done`, → IDLE.
- HEX frame:
  - Digit i = nibble i of value, with digit 0 rightmost.
  - Nibbles beyond WIDTH read 0.
  - Nibbles beyond DIGITS are dropped.
- DEC overflow: if value > 10^DIGITS − 1 (checked at capture), the frame is DASH on every digit; the conversion still runs its full length so latency stays fixed.
- `update` while `busy` is ignored; no queuing. The in-flight conversion completes unchanged.
- Frame register keeps the previous content throughout CONV; the display never shows a partial result.
- Scan:
  - Prescaler counts 0..SCAN_DIV−1.
  - On wrap, the scan index advances 0..DIGITS−1 and wraps to 0.
  - `dig_sel` = one-hot(index); `dig_code` = frame[index].
  - Scan runs continuously, independent of the FSM.

## Timing
- Reset values:
  - FSM IDLE; `busy` 0; `done` 0.
  - Frame all BLANK; prescaler 0; scan index 0.
  - `dig_sel` = 1 (digit 0); `dig_code` = 16.
- HEX latency: `update` at cycle 0 → COMMIT at cycle 1 → `done` and new frame visible at cycle 2.
- DEC/ONES/ZEROS latency: `update` at cycle 0 → CONV cycles 1..WIDTH → COMMIT at WIDTH+1 → `done` and frame at WIDTH+2.
- `busy` = 1 in CONV and COMMIT; 0 in IDLE. A new `update` is accepted in the cycle `done` is high.
- `dig_sel` and `dig_code` are registered and change together, SCAN_DIV cycles apart.
- When a frame commit coincides with a scan advance, the newly selected digit shows the new frame.
- Reset mid-conversion: immediate return to reset values, conversion discarded, no `done`.

## Configuration
- `DISPLAY_LZ_BLANK_EN` defined:
  - In DEC/ONES/ZEROS frames, leading zero digits are replaced by BLANK.
  - Digit 0 always shows its value, so 0 shows as a single "0".
  - HEX and DASH frames are unaffected.
- Undefined: all digits show their value, including leading zeros.

## Structure
- Shared package `display_pkg`:
  - Mode encodings: MODE_HEX, MODE_DEC, MODE_ONES, MODE_ZEROS.
  - Digit code width and constants: CODE_BLANK = 16, CODE_DASH = 17.
  - FSM state typedef.
- Sub-module `bin2bcd_seq`:
  - Parameters WIDTH, DIGITS.
  - Inputs: `start`, operand.
  - Outputs: BCD digits, `last` (asserted on the final shift cycle).
- Popcount, overflow compare, blanking, frame register and scan logic stay in the top level.

## Test plan
All scenarios use WIDTH = 16, DIGITS = 4, SCAN_DIV = 4.
- Reset, then HEX `update` with value 0xBEEF → `done` at cycle 2; frame B, E, E, F; scan shows `dig_sel` 0001 with code 15.
- DEC 1234 → `busy` for 17 cycles, `done` at cycle 18; frame 1, 2, 3, 4. DEC 65535 → frame all DASH (17), `done` at cycle 18.
- ONES of 0xF0F0 → frame 0, 0, 0, 8, or BLANK, BLANK, BLANK, 8 with `DISPLAY_LZ_BLANK_EN`. ZEROS of 0x0000 → 16.
- DEC 42, second `update` with 9999 at cycle 5 → ignored; frame shows 42. A further `update` 9999 in the `done` cycle → accepted; frame later shows 9999.
- Idle scan → `dig_sel` sequence 0001, 0010, 0100, 1000, 0001, changing every 4 cycles. Frame commit during slot 2 → the next slot shows the new digit.
- Assert `rst` at cycle 8 of a DEC conversion → `busy` 0, frame BLANK, no `done`. Next DEC 7 → normal 18-cycle completion.

Source files
------------

// File: rtl/display_pkg.sv
// Shared encodings for the display scan manager: mode codes, digit glyph codes,
// FSM state type and a constant helper for decimal range limits.
package display_pkg;

  localparam int CODE_W = 5;
  localparam logic [CODE_W-1:0] CODE_BLANK = 5'd16;
  localparam logic [CODE_W-1:0] CODE_DASH  = 5'd17;

  typedef enum logic [1:0] {
    MODE_HEX   = 2'd0,
    MODE_DEC   = 2'd1,
    MODE_ONES  = 2'd2,
    MODE_ZEROS = 2'd3
  } mode_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CONV   = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] r;
    r = 64'd1;
    for (int i = 0; i < n; i++) r = r * 64'd10;
    return r;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: one shift per clock, WIDTH clocks per
// conversion after start. last flags the final shift cycle.
module bin2bcd_seq #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WIDTH-1:0]      operand,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  last
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  logic               active;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   bin;
  logic [4*DIGITS-1:0] bcd_q;
  logic [4*DIGITS-1:0] bcd_adj;

  // Add-3 correction on every BCD digit that would exceed 9 after the shift.
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
  end

  assign last = active && (cnt == CNT_W'(WIDTH - 1));
  assign bcd  = bcd_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active <= 1'b0;
      cnt    <= '0;
    end else if (start) begin
      active <= 1'b1;
      cnt    <= '0;
    end else if (active) begin
      cnt <= cnt + 1'b1;
      if (last) active <= 1'b0;
    end
  end

  // Shift datapath carries no reset; start always reloads it.
  always_ff @(posedge clk) begin
    if (start) begin
      bin   <= operand;
      bcd_q <= '0;
    end else if (active) begin
      bcd_q <= {bcd_adj[4*DIGITS-2:0], bin[WIDTH-1]};
      bin   <= {bin[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/display_scan_manager.sv
// Captures a value, formats it (hex/dec/ones/zeros) into a digit frame and
// scans the frame onto a seven-segment bank. Option: DISPLAY_LZ_BLANK_EN.
module display_scan_manager
  import display_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               update,
  input  logic [WIDTH-1:0]   value,
  input  logic [1:0]         mode,
  output logic               busy,
  output logic               done,
  output logic [DIGITS-1:0]  dig_sel,
  output logic [4:0]         dig_code
);

  localparam int PAD_W = (WIDTH > 4*DIGITS) ? WIDTH : 4*DIGITS;
  localparam int PS_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [63:0] DEC_MAX = pow10(DIGITS) - 64'd1;

  state_t               state, state_nxt;
  logic                 accept, start, last, commit;
  logic [WIDTH-1:0]     operand;
  logic [WIDTH-1:0]     value_q;
  mode_t                mode_q;
  logic                 ovf_q;
  logic [4*DIGITS-1:0]  bcd;
  logic [PAD_W-1:0]     value_pad;
  logic [4:0]           frame     [DIGITS];
  logic [4:0]           frame_new [DIGITS];
  logic [4:0]           frame_nxt [DIGITS];
  logic [PS_W-1:0]      presc;
  logic [IX_W-1:0]      idx, idx_nxt;
  logic                 wrap;

  function automatic logic [WIDTH-1:0] popcount(input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] c;
    c = '0;
    for (int i = 0; i < WIDTH; i++) c = c + WIDTH'(v[i]);
    return c;
  endfunction

  assign accept = (state == ST_IDLE) && update;
  assign start  = accept && (mode_t'(mode) != MODE_HEX);
  assign commit = (state == ST_COMMIT);

  always_comb begin
    case (mode_t'(mode))
      MODE_ONES:  operand = popcount(value);
      MODE_ZEROS: operand = WIDTH'(WIDTH) - popcount(value);
      default:    operand = value;
    endcase
  end

  bin2bcd_seq #(
    .WIDTH  (WIDTH),
    .DIGITS (DIGITS)
  ) u_bin2bcd (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .operand (operand),
    .bcd     (bcd),
    .last    (last)
  );

  // Control FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= commit;
    end
  end

  always_comb begin
    state_nxt = state;
    busy      = (state != ST_IDLE);
    case (state)
      ST_IDLE: begin
        if (update) state_nxt = (mode_t'(mode) == MODE_HEX) ? ST_COMMIT : ST_CONV;
      end
      ST_CONV: begin
        if (last) state_nxt = ST_COMMIT;
      end
      ST_COMMIT: state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Capture registers; only read after a capture, so no reset needed.
  always_ff @(posedge clk) begin
    if (accept) begin
      value_q <= value;
      mode_q  <= mode_t'(mode);
      ovf_q   <= (mode_t'(mode) == MODE_DEC) && (64'(value) > DEC_MAX);
    end
  end

  assign value_pad = PAD_W'(value_q);

  // Frame formatting
  always_comb begin
    for (int i = 0; i < DIGITS; i++) frame_new[i] = CODE_BLANK;
    if (mode_q == MODE_HEX) begin
      for (int i = 0; i < DIGITS; i++) frame_new[i] = {1'b0, value_pad[4*i +: 4]};
    end else if (ovf_q) begin
      for (int i = 0; i < DIGITS; i++) frame_new[i] = CODE_DASH;
    end else begin
      for (int i = 0; i < DIGITS; i++) frame_new[i] = {1'b0, bcd[4*i +: 4]};
`ifdef DISPLAY_LZ_BLANK_EN
      begin
        logic lead;
        lead = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
          if (lead && (bcd[4*i +: 4] == 4'd0)) frame_new[i] = CODE_BLANK;
          else lead = 1'b0;
        end
      end
`endif
    end
  end

  always_comb begin
    for (int i = 0; i < DIGITS; i++) frame_nxt[i] = commit ? frame_new[i] : frame[i];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DIGITS; i++) frame[i] <= CODE_BLANK;
    end else begin
      for (int i = 0; i < DIGITS; i++) frame[i] <= frame_nxt[i];
    end
  end

  // Scan: the next frame is read so a commit on an advance edge shows at once.
  assign wrap    = (presc == PS_W'(SCAN_DIV - 1));
  assign idx_nxt = (idx == IX_W'(DIGITS - 1)) ? '0 : idx + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc    <= '0;
      idx      <= '0;
      dig_sel  <= DIGITS'(1);
      dig_code <= CODE_BLANK;
    end else if (wrap) begin
      presc    <= '0;
      idx      <= idx_nxt;
      dig_sel  <= DIGITS'(1) << idx_nxt;
      dig_code <= frame_nxt[idx_nxt];
    end else begin
      presc <= presc + 1'b1;
    end
  end

endmodule

// File: tb/tb_display_scan_manager.sv
// Directed bench for display_scan_manager (WIDTH=16, DIGITS=4, SCAN_DIV=4);
// expectations follow DISPLAY_LZ_BLANK_EN when it is defined.
module tb_display_scan_manager;

  logic        clk = 1'b0;
  logic        rst, update;
  logic [15:0] value;
  logic [1:0]  mode;
  logic        busy, done;
  logic [3:0]  dig_sel;
  logic [4:0]  dig_code;

  int n_vec = 0;
  int n_err = 0;

  display_scan_manager #(.WIDTH(16), .DIGITS(4), .SCAN_DIV(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .update   (update),
    .value    (value),
    .mode     (mode),
    .busy     (busy),
    .done     (done),
    .dig_sel  (dig_sel),
    .dig_code (dig_code)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [19:0] fr(input int d3, input int d2, input int d1, input int d0);
    return {d3[4:0], d2[4:0], d1[4:0], d0[4:0]};
  endfunction

  function automatic logic [19:0] lz(input logic [19:0] f);
    logic [19:0] r = f;
`ifdef DISPLAY_LZ_BLANK_EN
    logic lead;
    lead = 1'b1;
    for (int i = 3; i >= 1; i--) begin
      if (lead && r[5*i +: 5] == 5'd0) r[5*i +: 5] = 5'd16;
      else lead = 1'b0;
    end
`endif
    return r;
  endfunction

  // Called on a falling edge; returns on the falling edge of cycle 1.
  task automatic start_upd(input logic [15:0] v, input logic [1:0] m);
    update = 1'b1;
    value  = v;
    mode   = m;
    @(negedge clk);
    update = 1'b0;
  endtask

  task automatic wait_done(input int from, output int lat, output int bcnt);
    lat  = from;
    bcnt = 0;
    while (!done && lat < 60) begin
      if (busy) bcnt++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic read_frame(output logic [19:0] f);
    f = '1;
    for (int k = 0; k < 32; k++) begin
      @(negedge clk);
      for (int i = 0; i < 4; i++)
        if (dig_sel == (4'b0001 << i)) f[5*i +: 5] = dig_code;
    end
  endtask

  task automatic wait_fresh(input logic [3:0] sel);
    int n = 0;
    while (dig_sel == sel && n < 40) begin @(negedge clk); n++; end
    while (dig_sel != sel && n < 40) begin @(negedge clk); n++; end
    if (n >= 40) chk("fresh_timeout", n, 0);
  endtask

  initial begin
    int lat, bcnt, n, dcount;
    logic [19:0] f;
    logic [3:0]  prev;

    rst = 1'b1; update = 1'b0; value = '0; mode = 2'd0;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_sel", dig_sel, 4'b0001);
    chk("rst_code", dig_code, 16);
    rst = 1'b0;
    @(negedge clk);

    // HEX 0xBEEF
    start_upd(16'hBEEF, 2'd0);
    chk("hex_busy_c1", busy, 1);
    wait_done(1, lat, bcnt);
    chk("hex_lat", lat, 2);
    chk("hex_busy_done", busy, 0);
    read_frame(f);
    chk("hex_frame", f, fr(11, 14, 14, 15));
    n = 0;
    while (dig_sel != 4'b0001 && n < 40) begin @(negedge clk); n++; end
    chk("hex_d0_code", dig_code, 15);

    // DEC 1234
    start_upd(16'd1234, 2'd1);
    wait_done(1, lat, bcnt);
    chk("dec_lat", lat, 18);
    chk("dec_busy_cycles", bcnt, 17);
    read_frame(f);
    chk("dec_frame", f, lz(fr(1, 2, 3, 4)));

    // DEC overflow
    start_upd(16'd65535, 2'd1);
    wait_done(1, lat, bcnt);
    chk("ovf_lat", lat, 18);
    read_frame(f);
    chk("ovf_frame", f, fr(17, 17, 17, 17));

    // ONES and ZEROS
    start_upd(16'hF0F0, 2'd2);
    wait_done(1, lat, bcnt);
    chk("ones_lat", lat, 18);
    read_frame(f);
    chk("ones_frame", f, lz(fr(0, 0, 0, 8)));
    start_upd(16'h0000, 2'd3);
    wait_done(1, lat, bcnt);
    read_frame(f);
    chk("zeros_frame", f, lz(fr(0, 0, 1, 6)));

    // DEC 42 with an ignored update mid-conversion, then one in the done cycle
    start_upd(16'd42, 2'd1);
    repeat (4) @(negedge clk);
    start_upd(16'd9999, 2'd1);
    wait_done(6, lat, bcnt);
    chk("busy_ign_lat", lat, 18);
    start_upd(16'd9999, 2'd1);
    chk("done_cycle_accept", busy, 1);
    wait_done(1, lat, bcnt);
    chk("second_lat", lat, 18);
    read_frame(f);
    chk("second_frame", f, fr(9, 9, 9, 9));

    // Idle scan sequence and slot length
    prev = dig_sel;
    n = 0;
    while (dig_sel == prev && n < 20) begin @(negedge clk); n++; end
    for (int t = 0; t < 4; t++) begin
      prev = dig_sel;
      n = 0;
      while (dig_sel == prev && n < 20) begin @(negedge clk); n++; end
      chk("scan_slot_len", n, 4);
      chk("scan_next_sel", dig_sel, {prev[2:0], prev[3]});
    end

    // Commit inside slot 2: slot 3 shows the new digit 3
    wait_fresh(4'b0100);
    start_upd(16'h1234, 2'd0);
    n = 0;
    while (dig_sel != 4'b1000 && n < 20) begin @(negedge clk); n++; end
    chk("slot3_new_code", dig_code, 1);

    // Commit on the same edge as the advance into slot 3
    wait_fresh(4'b0100);
    repeat (2) @(negedge clk);
    start_upd(16'h5678, 2'd0);
    @(negedge clk);
    chk("coinc_done", done, 1);
    chk("coinc_sel", dig_sel, 4'b1000);
    chk("coinc_code", dig_code, 5);

    // Reset in cycle 8 of a DEC conversion
    repeat (2) @(negedge clk);
    start_upd(16'd1234, 2'd1);
    repeat (7) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_sel", dig_sel, 4'b0001);
    chk("mid_rst_code", dig_code, 16);
    @(negedge clk);
    rst = 1'b0;
    dcount = 0;
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      if (done) dcount++;
    end
    chk("mid_rst_no_done", dcount, 0);
    read_frame(f);
    chk("mid_rst_frame", f, fr(16, 16, 16, 16));
    start_upd(16'd7, 2'd1);
    wait_done(1, lat, bcnt);
    chk("post_rst_lat", lat, 18);
    read_frame(f);
    chk("post_rst_frame", f, lz(fr(0, 0, 0, 7)));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
